cv32e40x_clock_gate_ctrl: RTL
=============================

// Module: cv32e40x_clock_gate_ctrl
// PURPOSE
// - Generates the enable for the core clock gate (feeds en_i of the core's clock gate cell).
// - Runs on the UNGATED clock. Sequences the core into sleep (WFI) once the fetch and LSU
//   buses are idle. Brings the core back on an interrupt or a debug request, with a
//   programmable wake-up settle time.
// PARAMETERS
// - IDLE_CYCLES  default 2   extra consecutive idle cycles required in DRAIN before gating (0..15)
// - WAKE_CYCLES  default 2   cycles clock is re-enabled before core released (0..15)
// PORTS
// - clk_i          in   1   ungated core clock
// - rst_ni         in   1   reset, asynchronous, active-low
// - sleep_req_i    in   1   WFI retired; request to sleep, sampled only in RUN
// - wake_irq_i     in   1   pending enabled interrupt (level)
// - debug_req_i    in   1   external debug request (level)
// - fetch_busy_i   in   1   instruction bus has outstanding transaction
// - lsu_busy_i     in   1   data bus has outstanding transaction
// - clk_gate_en_o  out  1   enable to clock gate; 1 = core clock running
// - core_sleep_o   out  1   core is in sleep/wake sequence (DRAIN excluded)
// - wake_o         out  1   1-cycle pulse on return to RUN from WAKE or aborted DRAIN
// - sleep_cycles_o out  32  cycles spent in SLEEP (optional feature, see CONFIGURATION)
// - sleep_cnt_clr_i in  1   synchronous clear of sleep_cycles_o
// BEHAVIOUR
// - Reset: state=RUN, clk_gate_en_o=1, core_sleep_o=0, wake_o=0, counters=0, sleep_cycles_o=0.
// - All outputs are registered / decoded from the state register only; no combinational input->output path.
// - wake = wake_irq_i | debug_req_i; wake has priority over every other transition.
// - FSM, 2-bit state:
//   - RUN: gate_en=1, sleep=0.
//     - sleep_req_i & !wake -> DRAIN, idle_cnt=0.
//     - sleep_req_i & wake -> stay RUN; no wake_o.
//   - DRAIN: gate_en=1, sleep=0.
//     - wake -> RUN, wake_o pulse.
//     - else busy (fetch|lsu) -> idle_cnt=0.
//     - else idle_cnt==IDLE_CYCLES -> SLEEP.
//     - else idle_cnt++.
//     - Net effect: IDLE_CYCLES+1 consecutive idle cycles are needed.
//   - SLEEP: gate_en=0, sleep=1.
//     - wake -> WAKE with wake_cnt=WAKE_CYCLES.
//     - If WAKE_CYCLES==0 -> RUN directly, with wake_o pulse.
//   - WAKE: gate_en=1, sleep=1.
//     - wake_cnt-- each cycle; when wake_cnt==1 -> RUN.
//     - wake_o=1 on the first RUN cycle.
//     - wake deasserting during WAKE does not abort the sequence.
// - sleep_req_i outside RUN is ignored (not queued).
// - Busy inputs are ignored in SLEEP/WAKE.
// - Counters are 4-bit and never wrap (bounded by parameters).
// - Reset mid-sequence: async return to RUN with clock enabled the same instant rst_ni falls.
// CONFIGURATION
// - CV32E40X_SLEEP_STATS_EN defined:
//   - sleep_cycles_o increments each cycle in SLEEP and saturates at 32'hFFFF_FFFF.
//   - sleep_cnt_clr_i forces 0 and wins over increment.
// - Undefined: sleep_cycles_o tied to 0, sleep_cnt_clr_i ignored, no counter flops.
// TESTING
// - Reset: rst_ni low mid-SLEEP -> clk_gate_en_o=1, core_sleep_o=0 immediately; RUN after release.
// - Sleep entry: defaults, sleep_req_i at cyc 10, buses idle -> DRAIN 11-13, clk_gate_en_o=0 from cyc 14.
// - Busy drain: lsu_busy_i high cyc 11-15 -> clk_gate_en_o falls at cyc 19 (3 idle cycles after busy drops).
// - Wake: SLEEP, wake_irq_i at cyc 20 -> gate_en=1 cyc 21, WAKE 21-22, RUN+wake_o=1 at 23, core_sleep_o=0 at 23.
// - Abort: debug_req_i during DRAIN -> RUN next cycle, wake_o pulse, clock never gated.
// - Stats (macro on): 50 cycles in SLEEP -> sleep_cycles_o=50; clr+SLEEP same cycle -> 0; preload 32'hFFFF_FFFF holds.

Source files
------------

// File: rtl/cv32e40x_clock_gate_ctrl.sv
// Core clock-gate enable sequencer: drains buses before WFI sleep, settles the clock on wake-up.
// Optional sleep-cycle statistics counter enabled by defining CV32E40X_SLEEP_STATS_EN.
module cv32e40x_clock_gate_ctrl #(
  parameter int unsigned IDLE_CYCLES = 2,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        sleep_req_i,
  input  logic        wake_irq_i,
  input  logic        debug_req_i,
  input  logic        fetch_busy_i,
  input  logic        lsu_busy_i,
  output logic        clk_gate_en_o,
  output logic        core_sleep_o,
  output logic        wake_o,
  output logic [31:0] sleep_cycles_o,
  input  logic        sleep_cnt_clr_i
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned STAT_W = 32;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SLEEP = 2'd2,
    ST_WAKE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0]   wake_cnt_q, wake_cnt_d;
  logic               gate_en_q, gate_en_d;
  logic               sleep_q, sleep_d;
  logic               wake_pulse_q, wake_pulse_d;
  logic               wake_c;
  logic               busy_c;

  assign wake_c = wake_irq_i | debug_req_i;
  assign busy_c = fetch_busy_i | lsu_busy_i;

  // State register plus registered outputs derived from the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_RUN;
      idle_cnt_q   <= '0;
      wake_cnt_q   <= '0;
      gate_en_q    <= 1'b1;
      sleep_q      <= 1'b0;
      wake_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idle_cnt_q   <= idle_cnt_d;
      wake_cnt_q   <= wake_cnt_d;
      gate_en_q    <= gate_en_d;
      sleep_q      <= sleep_d;
      wake_pulse_q <= wake_pulse_d;
    end
  end

  // Next-state logic; a wake source always takes priority.
  always_comb begin
    state_d      = state_q;
    idle_cnt_d   = idle_cnt_q;
    wake_cnt_d   = wake_cnt_q;
    wake_pulse_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (sleep_req_i && !wake_c) begin
          state_d    = ST_DRAIN;
          idle_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        if (wake_c) begin
          state_d      = ST_RUN;
          wake_pulse_d = 1'b1;
        end else if (busy_c) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == CNT_W'(IDLE_CYCLES)) begin
          state_d = ST_SLEEP;
        end else begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
      end
      ST_SLEEP: begin
        if (wake_c) begin
          if (WAKE_CYCLES == 0) begin
            state_d      = ST_RUN;
            wake_pulse_d = 1'b1;
          end else begin
            state_d    = ST_WAKE;
            wake_cnt_d = CNT_W'(WAKE_CYCLES);
          end
        end
      end
      ST_WAKE: begin
        // Settle window runs to completion even if the wake source drops.
        if (wake_cnt_q <= CNT_W'(1)) begin
          state_d      = ST_RUN;
          wake_cnt_d   = '0;
          wake_pulse_d = 1'b1;
        end else begin
          wake_cnt_d = wake_cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
    gate_en_d = (state_d != ST_SLEEP);
    sleep_d   = (state_d == ST_SLEEP) || (state_d == ST_WAKE);
  end

  assign clk_gate_en_o = gate_en_q;
  assign core_sleep_o  = sleep_q;
  assign wake_o        = wake_pulse_q;

`ifdef CV32E40X_SLEEP_STATS_EN
  logic [STAT_W-1:0] sleep_cycles_q;

  // Saturating count of cycles spent gated; clear wins over increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sleep_cycles_q <= '0;
    end else if (sleep_cnt_clr_i) begin
      sleep_cycles_q <= '0;
    end else if ((state_q == ST_SLEEP) && (sleep_cycles_q != '1)) begin
      sleep_cycles_q <= sleep_cycles_q + STAT_W'(1);
    end
  end

  assign sleep_cycles_o = sleep_cycles_q;
`else
  logic unused_clr;

  assign unused_clr     = sleep_cnt_clr_i;
  assign sleep_cycles_o = STAT_W'(0);
`endif

endmodule
